// File: rtl/padded_row_pkg.sv
// Shared types and helpers for the padded row scheduler: FSM states,
// lane geometry and the column-major read-address formula.
package padded_row_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SWITCH,
      PAD,
      FETCH,
      DRAIN,
      EMIT,
      DONE
   } sched_state_t;

   localparam int LANE_W = 8;

   function automatic int row_w(input int img_w);
      return img_w + 2;
   endfunction

   // Buffer is column-major; padded row r maps to image row r-1.
   function automatic int unsigned rd_addr(input int unsigned col,
                                           input int unsigned row,
                                           input int unsigned img_h);
      return col * img_h + row - 1;
   endfunction

endpackage

// File: rtl/padded_row_scheduler_if.sv
// Read-port and PE-row bundle between the scheduler (master) and the
// ping-pong buffer / PE array (slave).
interface padded_row_scheduler_if
   import padded_row_pkg::*;
#(
   parameter int IMG_W  = 32,
   parameter int ADDR_W = 16
);

   logic                            o_rd_en;
   logic [ADDR_W-1:0]               o_rd_addr;
   logic [LANE_W-1:0]               i_rd_data;
   logic [LANE_W*row_w(IMG_W)-1:0]  o_row_data;
   logic                            o_row_vld;
   logic                            i_row_rdy;
   logic [5:0]                      o_row_idx;

   modport master (
      output o_rd_en, o_rd_addr, o_row_data, o_row_vld, o_row_idx,
      input  i_rd_data, i_row_rdy
   );

   modport slave (
      input  o_rd_en, o_rd_addr, o_row_data, o_row_vld, o_row_idx,
      output i_rd_data, i_row_rdy
   );

endinterface

// File: rtl/row_lane_register.sv
// Holds one padded row as NUM_LANES bytes; lane 0 is the MSB byte of row_data.
// Contents are frozen while the row is being offered downstream.
module row_lane_register
   import padded_row_pkg::*;
#(
   parameter int NUM_LANES = 34,
   parameter int IDX_W     = $clog2(NUM_LANES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        hold,
   input  logic                        fill_pad,
   input  logic                        edge_pad,
   input  logic [LANE_W-1:0]           pad_byte,
   input  logic                        wr_en,
   input  logic [IDX_W-1:0]            wr_lane,
   input  logic [LANE_W-1:0]           wr_data,
   output logic [LANE_W*NUM_LANES-1:0] row_data
);

   logic [LANE_W-1:0] lane_q [NUM_LANES];

   // Fill-all takes priority; edge lanes and data lanes never overlap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= '0;
      end else if (!hold) begin
         if (fill_pad) begin
            for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= pad_byte;
         end else begin
            if (edge_pad) begin
               lane_q[0]           <= pad_byte;
               lane_q[NUM_LANES-1] <= pad_byte;
            end
            if (wr_en) lane_q[wr_lane] <= wr_data;
         end
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_pack
      assign row_data[(NUM_LANES-1-k)*LANE_W +: LANE_W] = lane_q[k];
   end

endmodule

// File: rtl/padded_row_scheduler.sv
// Sequences one frame out of the ping-pong buffer: swaps banks, fetches each
// image row column-major, and emits zero-padded rows to the PE array.
module padded_row_scheduler
   import padded_row_pkg::*;
#(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    i_buf_ready,
   input  logic [LANE_W-1:0]       i_pad_value,
   output logic                    o_switch_pingpong,
   padded_row_scheduler_if.master  bus,
   output logic                    o_frame_done,
   output logic                    o_busy
);

   localparam int ROW_LANES = row_w(IMG_W);
   localparam int ROW_CW    = $clog2(IMG_H + 3);
   localparam int COL_CW    = $clog2(IMG_W + 1);
   localparam int LANE_IW   = $clog2(ROW_LANES);
   localparam logic [ROW_CW-1:0] LAST_ROW = ROW_CW'(IMG_H + 1);
   localparam logic [COL_CW-1:0] LAST_COL = COL_CW'(IMG_W - 1);

   if (IMG_H + 1 > 63) begin : g_bad_height
      $error("IMG_H+1 does not fit the 6-bit row index");
   end
   if (ADDR_W < $clog2(IMG_W * IMG_H)) begin : g_bad_addr
      $error("ADDR_W too narrow for IMG_W*IMG_H");
   end

   sched_state_t         state_q, state_d;
   logic [ROW_CW-1:0]    row_q, row_d;
   logic [COL_CW-1:0]    col_q, col_d;
   logic [LANE_W-1:0]    pad_q, pad_d;
   logic                 rd_pend_q;
   logic [LANE_IW-1:0]   rd_lane_q;
   logic                 rd_en, switch_pulse, done_pulse, fill_pad, edge_pad;
   logic                 row_vld;
   logic [ADDR_W-1:0]    addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         pad_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         pad_q   <= pad_d;
      end
   end

   // Every state except EMIT waits on en; a pending handshake is never
   // blocked so that valid cannot fall without acceptance.
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      pad_d        = pad_q;
      rd_en        = 1'b0;
      switch_pulse = 1'b0;
      done_pulse   = 1'b0;
      fill_pad     = 1'b0;
      edge_pad     = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && i_buf_ready) state_d = SWITCH;
         end
         SWITCH: begin
            if (en) begin
               switch_pulse = 1'b1;
               pad_d        = i_pad_value;
               row_d        = '0;
               col_d        = '0;
               state_d      = PAD;
            end
         end
         PAD: begin
            if (en) begin
               fill_pad = 1'b1;
               state_d  = EMIT;
            end
         end
         FETCH: begin
            if (en) begin
               rd_en    = 1'b1;
               edge_pad = (col_q == '0);
               if (col_q == LAST_COL) begin
                  col_d   = '0;
                  state_d = DRAIN;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (en) state_d = EMIT;
         end
         EMIT: begin
            if (bus.i_row_rdy) begin
               row_d = row_q + 1'b1;
               if (row_q == LAST_ROW)      state_d = DONE;
               else if (row_d == LAST_ROW) state_d = PAD;
               else                        state_d = FETCH;
            end
         end
         DONE: begin
            if (en) begin
               done_pulse = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read data arrives one cycle after the strobe, independent of en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend_q <= 1'b0;
         rd_lane_q <= '0;
      end else begin
         rd_pend_q <= rd_en;
         rd_lane_q <= LANE_IW'(col_q + 1'b1);
      end
   end

   assign addr    = ADDR_W'(rd_addr(32'(col_q), 32'(row_q), IMG_H));
   assign row_vld = (state_q == EMIT);

   row_lane_register #(
      .NUM_LANES (ROW_LANES)
   ) u_lanes (
      .clk      (clk),
      .rst      (rst),
      .hold     (row_vld),
      .fill_pad (fill_pad),
      .edge_pad (edge_pad),
      .pad_byte (pad_q),
      .wr_en    (rd_pend_q),
      .wr_lane  (rd_lane_q),
      .wr_data  (bus.i_rd_data),
      .row_data (bus.o_row_data)
   );

   assign bus.o_rd_en        = rd_en;
   assign bus.o_rd_addr      = rd_en ? addr : '0;
   assign bus.o_row_vld      = row_vld;
   assign bus.o_row_idx      = row_vld ? 6'(row_q) : 6'd0;
   assign o_switch_pingpong  = switch_pulse;
   assign o_frame_done       = done_pulse;
   assign o_busy             = (state_q != IDLE);

endmodule

// File: tb/tb_padded_row_scheduler.sv
// Randomized bench for padded_row_scheduler at 4x4 against a frame-level
// reference model of the expected rows, read addresses and pulses.
module tb_padded_row_scheduler;
   import padded_row_pkg::*;

   localparam int W     = 4;
   localparam int H     = 4;
   localparam int AW    = 16;
   localparam int NLANE = W + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       buf_ready;
   logic [7:0] pad_value;
   logic       sw;
   logic       done;
   logic       busy;

   padded_row_scheduler_if #(.IMG_W(W), .ADDR_W(AW)) bus ();

   padded_row_scheduler #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk               (clk),
      .rst               (rst),
      .en                (en),
      .i_buf_ready       (buf_ready),
      .i_pad_value       (pad_value),
      .o_switch_pingpong (sw),
      .bus               (bus),
      .o_frame_done      (done),
      .o_busy            (busy)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [W*H];

   // Inactive-bank model: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr[3:0]];
   end

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
                  tag, observed, expected, cyc);
      end
   endtask

   bit         model_idle = 1'b1;
   bit         sw_pending, done_pending, prev_stall, trig;
   int         exp_row, exp_rd, sw_cycle, done_cycle, frames_done, switches;
   logic [7:0] exp_pad;
   logic [63:0] prev_data;
   logic [5:0] prev_idx;

   function automatic logic [63:0] expRow(input int r);
      logic [63:0] v;
      logic [7:0]  b;
      v = '0;
      for (int l = 0; l < NLANE; l++) begin
         if (r == 0 || r == H + 1 || l == 0 || l == NLANE - 1) b = exp_pad;
         else b = mem[(l - 1) * H + r - 1];
         v = {v[55:0], b};
      end
      return v;
   endfunction

   // Frame-level reference: pulses, busy, read order, row contents, holds.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         checkOutput("reset_ctrl", {sw, bus.o_rd_en, bus.o_rd_addr, bus.o_row_vld,
                                    bus.o_row_idx, done, busy}, '0);
         checkOutput("reset_row", 64'(bus.o_row_data), '0);
         model_idle   = 1'b1;
         sw_pending   = 1'b0;
         done_pending = 1'b0;
         prev_stall   = 1'b0;
         exp_row      = 0;
         exp_rd       = 0;
      end else begin
         trig = model_idle && en && buf_ready;
         checkOutput("switch_pulse", sw, sw_pending && en);
         checkOutput("busy", busy, !model_idle);
         checkOutput("frame_done", done, done_pending && en);
         if (sw_pending && en) begin
            sw_pending = 1'b0;
            exp_pad    = pad_value;
            exp_row    = 0;
            exp_rd     = 0;
            sw_cycle   = cyc;
            switches++;
         end
         if (done_pending && en) begin
            done_pending = 1'b0;
            model_idle   = 1'b1;
            done_cycle   = cyc;
            frames_done++;
         end
         if (bus.o_rd_en) begin
            checkOutput("rd_gate", {en, bus.o_row_vld}, 2'b10);
            checkOutput("rd_addr", {exp_rd < W * H, bus.o_rd_addr},
                        {1'b1, 16'((exp_rd % W) * H + exp_rd / W)});
            exp_rd++;
         end
         if (prev_stall)
            checkOutput("vld_hold", {bus.o_row_vld, bus.o_row_idx, bus.o_row_data},
                        {1'b1, prev_idx, prev_data[47:0]});
         if (bus.o_row_vld && bus.i_row_rdy) begin
            checkOutput("row_idx", bus.o_row_idx, 64'(exp_row));
            checkOutput("row_data", 64'(bus.o_row_data), expRow(exp_row));
            if (exp_row == H + 1) done_pending = 1'b1;
            exp_row++;
         end
         prev_stall = bus.o_row_vld && !bus.i_row_rdy;
         prev_idx   = bus.o_row_idx;
         prev_data  = 64'(bus.o_row_data);
         if (trig) begin
            sw_pending = 1'b1;
            model_idle = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input bit e, input bit br, input logic [7:0] p,
                                input bit r);
      en            = e;
      buf_ready     = br;
      pad_value     = p;
      bus.i_row_rdy = r;
      @(posedge clk);
      #1;
   endtask

   // mode 0 plain, 1 backpressure on row 2, 2 enable stall in row 1,
   // 3 reset during row 3 fetch.
   task automatic runFrame(input int en_pct, input int rdy_pct, input int mode,
                           input logic [7:0] pad_a, input logic [7:0] pad_b,
                           input bit hold_ready);
      int start    = frames_done;
      int sw_start = switches;
      int hold_cnt = 0;
      int stall    = 0;
      bit hit      = 1'b0;
      bit e, r, br;
      logic [7:0] p;
      for (int t = 0; t < 3000; t++) begin
         e  = (t == 0) || ($urandom_range(99) < en_pct);
         r  = $urandom_range(99) < rdy_pct;
         br = hold_ready || (t == 0);
         p  = (switches > sw_start && exp_row >= 3) ? pad_b : pad_a;
         if (mode == 1 && bus.o_row_vld && bus.o_row_idx == 6'd2 && hold_cnt < 10) begin
            r = 1'b0;
            hold_cnt++;
         end
         if (mode == 2 && exp_row == 1 && exp_rd == 2 && stall < 3) begin
            e = 1'b0;
            stall++;
         end
         if (mode == 3 && exp_row == 3 && exp_rd == 2 * W + 2) begin
            hit = 1'b1;
            rst = 1'b1;
            #1;
            checkOutput("reset_immediate", {bus.o_rd_en, busy, bus.o_row_vld}, '0);
            applyStimulus(1'b1, 1'b0, pad_a, 1'b1);
            applyStimulus(1'b1, 1'b0, pad_a, 1'b1);
            checkOutput("abort_no_done", 64'(frames_done), 64'(start));
            rst = 1'b0;
            break;
         end
         applyStimulus(e, br, p, r);
         if (frames_done > start) break;
      end
      if (mode == 3) checkOutput("reset_point", hit, 1'b1);
      else checkOutput("frame_complete", frames_done > start, 1'b1);
      if (mode == 1) checkOutput("bp_cycles", 64'(hold_cnt), 64'd10);
      if (mode == 2) checkOutput("stall_cycles", 64'(stall), 64'd3);
   endtask

   int sw_before;

   initial begin
      rst           = 1'b1;
      en            = 1'b0;
      buf_ready     = 1'b0;
      pad_value     = 8'h00;
      bus.i_row_rdy = 1'b0;
      for (int i = 0; i < W * H; i++) mem[i] = 8'(i);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] basic frame");
      runFrame(100, 100, 0, 8'hAA, 8'hAA, 1'b0);
      checkOutput("frame_cycles", 64'(done_cycle - sw_cycle + 1), 64'd30);

      $display("[TB] backpressure");
      runFrame(100, 100, 1, 8'hAA, 8'hAA, 1'b0);

      $display("[TB] enable stall");
      runFrame(100, 100, 2, 8'hAA, 8'hAA, 1'b0);

      $display("[TB] reset mid-frame");
      runFrame(100, 100, 3, 8'hAA, 8'hAA, 1'b0);
      sw_before = switches;
      runFrame(100, 100, 0, 8'hAA, 8'hAA, 1'b0);
      checkOutput("switch_after_reset", 64'(switches - sw_before), 64'd1);

      $display("[TB] back-to-back and pad latch");
      for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
      sw_before = switches;
      runFrame(100, 100, 0, 8'hAA, 8'h55, 1'b1);
      runFrame(100, 100, 0, 8'h55, 8'h55, 1'b1);
      runFrame(100, 100, 0, 8'h55, 8'h55, 1'b0);
      checkOutput("switch_count", 64'(switches - sw_before), 64'd3);

      $display("[TB] randomized frames");
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
         pad_value = 8'($urandom);
         runFrame(75, 65, 0, pad_value, pad_value, 1'b0);
      end

      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput("final_idle", {busy, bus.o_row_vld}, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/padded_row_scheduler.md
Name: padded_row_scheduler

Overview:
- Single-clock controller that sequences one frame out of the ping-pong input buffer.
- Flips the bank when a frame is ready, then issues read addresses into the column-major buffer.
- Assembles each zero-padded row (IMG_W+2 bytes, pad bytes on both edges plus full pad rows top and bottom) and hands it to the PE array over a valid/ready handshake.
- Sits between the PingPongBuffer read port and the PE row input, replacing ad-hoc row/column counting.

Parameters:
- IMG_W, 32, image columns (real pixels per row)
- IMG_H, 32, image rows (real pixels per column)
- ADDR_W, 16, buffer read-address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  sole clock (buffer read side and PE side)
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; low stalls sequencing
- i_buf_ready  in  1  inactive bank holds a complete frame
- i_pad_value  in  8  padding byte value
- o_switch_pingpong  out  1  one-cycle pulse: swap banks
- o_rd_en  out  1  buffer read strobe
- o_rd_addr  out  ADDR_W  buffer read address
- i_rd_data  in  8  read data, valid exactly 1 cycle after o_rd_en
- o_row_data  out  8*(IMG_W+2)  padded row; lane 0 = MSB byte
- o_row_vld  out  1  row valid
- i_row_rdy  in  1  PE accepts row
- o_row_idx  out  6  padded row index 0..IMG_H+1 of o_row_data
- o_frame_done  out  1  one-cycle pulse after last row accepted
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, row/col counters 0, latched pad byte 0. Asynchronous reset mid-frame aborts the frame with no switch pulse and no done pulse.
- FSM states: IDLE, SWITCH, PAD, FETCH, DRAIN, EMIT, DONE.
- IDLE:
  - If en && i_buf_ready, go to SWITCH. i_buf_ready is sampled only in IDLE.
- SWITCH:
  - o_switch_pingpong=1 for this cycle only; latch i_pad_value; row=0; go to PAD.
- PAD (row 0 or row IMG_H+1):
  - Load all IMG_W+2 lanes with the latched pad byte; go to EMIT next cycle.
- FETCH (row r in 1..IMG_H):
  - Lanes 0 and IMG_W+1 = pad byte.
  - For col c = 0..IMG_W-1 on consecutive enabled cycles: o_rd_en=1, o_rd_addr = c*IMG_H + (r-1), truncated to ADDR_W.
  - Data returning one cycle later is written to lane c+1.
  - After issuing c=IMG_W-1, go to DRAIN.
- DRAIN:
  - Capture the last data into lane IMG_W; go to EMIT.
- EMIT:
  - o_row_vld=1, o_row_idx=row; o_row_data is held stable until handshake (o_row_vld && i_row_rdy).
  - On handshake, o_row_vld falls next cycle and row increments.
  - Next state: PAD if new row==IMG_H+1; FETCH if new row <= IMG_H; DONE if the accepted row was IMG_H+1.
- DONE:
  - o_frame_done=1 for one cycle; go to IDLE.
- en=0:
  - No state or counter change and no o_rd_en.
  - A read issued in the prior cycle is still captured.
  - In EMIT, o_row_vld stays high and a handshake is still honoured. Once asserted, valid never drops without a handshake.
- Timing:
  - Row latency with en held high: FETCH entry to o_row_vld = IMG_W+1 cycles.
  - Minimum frame duration with i_row_rdy held high: 1 + 2*2 + IMG_H*(IMG_W+2) + 1 cycles. This is 1094 cycles at 32x32.
- o_row_idx is 6 bits, so IMG_H+1 must be <= 63 (elaboration check).
- Counters are sized by $clog2. Row comparisons use full width, with no wrap during a frame.

Decomposition:
- Package padded_row_pkg:
  - state enum
  - LANE_W=8
  - ROW_W=IMG_W+2 helper
  - function rd_addr(col,row)
- One sub-module, row_lane_register, holds the ROW_W-lane row with:
  - per-lane write (lane index + byte)
  - a fill-all-with-pad operation
  - a hold-while-valid rule
- The FSM and counters stay in the top.

Test Plan:
- Basic frame: IMG_W=IMG_H=4, i_pad_value=0xAA, buffer addr n returns n; pulse i_buf_ready, i_row_rdy=1 -> one switch pulse; 6 rows; row 0 all 0xAA; row 1 = AA,00,04,08,0C,AA; row 5 all 0xAA; o_frame_done 1 cycle after row 5 handshake; total 1+4+4*6+1=30 cycles.
- Backpressure: hold i_row_rdy=0 for 10 cycles during row 2 -> o_row_vld and o_row_data stable for all 10 cycles, o_row_idx=2, no extra o_rd_en, accepted on the first rdy cycle.
- Enable stall: drop en for 3 cycles after col 1 issued in row 1 -> col 1 data still lands in lane 2; addresses resume at col 2; final row identical to the no-stall run.
- Reset mid-frame: assert rst during FETCH of row 3 -> all outputs 0 immediately; after release with i_buf_ready=1, a fresh frame starts at row 0 with exactly one new switch pulse.
- Busy-ignore and back-to-back: i_buf_ready held high through two frames -> no switch pulse while o_busy=1; the second switch pulse comes the cycle after IDLE is re-entered; o_rd_addr never exceeds 15 for 4x4.
- Pad latch: change i_pad_value from 0xAA to 0x55 mid-frame -> the whole frame keeps 0xAA; the next frame uses 0x55.
